board_sequencer: RTL and testbench
==================================

# board_sequencer

Sequencer and owner of the single-port 9-cell board RAM in the tic-tac-toe design. Accepts move-write requests from `gameController`, checks target-cell occupancy, and performs the write. After each move, it scans the whole board and drives `gameIsDone`, the winner and draw flags back to the controller. After reset, it clears the board to EMPTY before accepting any move.

## Interface
Parameters:
- `CELLS`, 9: board cells; valid addresses 0..8.
- `AW`, 4: board address width.

Ports:
- `ph1`  in  1  single clock; all state updates on rising edge (block does not use `ph2`)
- `reset`  in  1  synchronous, active-high
- `wrReq`  in  1  move request; held until `wrGrant` or `illegalMove`
- `wrAddr`  in  AW  target cell
- `wrCell`  in  2  cell value to write; legal values X=2'b10, O=2'b11
- `wrGrant`  out  1  one-cycle pulse: move written
- `illegalMove`  out  1  one-cycle pulse: move rejected
- `memAddr`  out  AW  board RAM address
- `memWe`  out  1  board RAM write enable
- `memWData`  out  2  board RAM write data
- `memRData`  in  2  board RAM read data; valid one cycle after `memAddr`
- `busy`  out  1  high in every state except IDLE and DONE
- `gameIsDone`  out  1  game over; high in DONE
- `winner`  out  2  X, O, or EMPTY (2'b00) for draw or no result
- `isDraw`  out  1  board full, no line

## Operation
- Cell encoding: EMPTY=00, X=10, O=11. Code 01 is read as EMPTY.
- States: CLEAR, IDLE, RDCHK, VERIFY, WRITE, SCAN, EVAL, DONE.
- While `reset`=1, outputs are forced: `memWe`=0, `memAddr`=0, `memWData`=00, pulses=0, `gameIsDone`=0, `winner`=00, `isDraw`=0, `busy`=1. Next state is CLEAR with index 0 and move count 0.
- CLEAR: `memWe`=1, `memWData`=00, `memAddr`=index 0..8, one cell per cycle; after index 8 → IDLE.
- IDLE:
  - `wrReq`=1 with `wrAddr`>8, or `wrCell`∈{00,01}: pulse `illegalMove` next cycle, stay IDLE.
  - `wrReq`=1 and legal: → RDCHK.
- RDCHK: `memAddr`=`wrAddr`, `memWe`=0 → VERIFY.
- VERIFY:
  - `memRData` non-EMPTY: pulse `illegalMove`, → IDLE.
  - Otherwise → WRITE.
- WRITE: `memWe`=1, `memAddr`=`wrAddr`, `memWData`=`wrCell`, `wrGrant`=1, move count +1 → SCAN.
- SCAN: drives addresses 0..8 on consecutive cycles, then one trailing capture cycle (10 cycles total). `memRData` is captured into a 9-entry shadow board one cycle after each address.
- EVAL: examines the 8 lines (3 rows, 3 columns, 2 diagonals).
  - Any line with 3 equal non-EMPTY cells: latch `winner`, → DONE. X has priority if both players have a line.
  - Else move count = 9: `isDraw`=1, → DONE.
  - Else → IDLE.
- DONE: `gameIsDone`=1; `winner` and `isDraw` held. `wrReq` ignored (no pulses). Exit only via reset.
- Move count is 4 bits and saturates at 9.

## Timing
- Reset deassert at edge r: CLEAR writes occur during cycles r..r+8; IDLE from r+9.
- `wrReq` sampled high in IDLE at edge n: RDCHK in n+1, VERIFY in n+2, WRITE/`wrGrant` in n+3, SCAN n+4..n+13, EVAL n+14. Result (`gameIsDone` or IDLE) in n+15.
- Occupied cell: `illegalMove` in cycle n+3, IDLE in n+3, no write.
- Out-of-range address or bad `wrCell`: `illegalMove` in cycle n+1.
- Requester drops `wrReq` the cycle after either pulse. A `wrReq` still high in IDLE is treated as a new request.
- Reset mid-SCAN or mid-WRITE: the pending write is abandoned and the board is re-cleared. `wrGrant` is never pulsed after reset is asserted.

## Structure
- Shared package `tictactoe_pkg` holds:
  - the `cellStateType` enum (EMPTY/X/O),
  - `CELLS`,
  - the constant 8×3 line table of cell indices,
  - the `board_sequencer` state enum.
- Sub-module `win_detect`: combinational; 9×2-bit shadow board in; `winner` (2) and `anyLine` out; uses the package line table.

## Test plan
- Reset held 2 cycles, then release → `memWe`=1 for exactly 9 cycles at addresses 0..8 with data 00; `busy` drops on cycle r+9.
- Move X@4 → `wrGrant` at n+3, RAM[4]=10, IDLE at n+15, `gameIsDone`=0.
- Second move O@4 → `illegalMove` at n+3, no `memWe`, RAM[4] stays 10.
- Moves X@0, O@3, X@1, O@4, X@2 → after the fifth move: `gameIsDone`=1, `winner`=10; a subsequent `wrReq` produces no pulse.
- Full board X0 O1 X2 X3 O4 O5 O6 X7 X8 (no line) → after the ninth move: `isDraw`=1, `winner`=00, `gameIsDone`=1.
- `wrAddr`=9, or `wrCell`=01 → `illegalMove` at n+1. Separately, reset asserted during SCAN → CLEAR runs, no `wrGrant`, board all 00.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe types: cell encoding, board size, winning-line table
// and the board sequencer state encoding.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b10,
    O     = 2'b11
  } cellStateType;

  localparam int CELLS = 9;
  localparam int LINES = 8;

  // Rows, then columns, then the two diagonals.
  localparam logic [3:0] LINE_TABLE [LINES][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RDCHK  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_WRITE  = 3'd4,
    ST_SCAN   = 3'd5,
    ST_EVAL   = 3'd6,
    ST_DONE   = 3'd7
  } seq_state_t;

endpackage

// File: rtl/board_sequencer_win_detect.sv
// Combinational line checker over the shadow board; X wins ties because
// both players can only hold lines simultaneously after a faulty board.
module win_detect
  import tictactoe_pkg::*;
(
  input  logic [CELLS-1:0][1:0] board,
  output logic [1:0]            winner,
  output logic                  anyLine
);

  logic x_line_s;
  logic o_line_s;

  // Exact compares against X/O make the unused 01 code count as empty.
  always_comb begin
    x_line_s = 1'b0;
    o_line_s = 1'b0;
    for (int l = 0; l < LINES; l++) begin
      x_line_s = x_line_s | ((board[LINE_TABLE[l][0]] == X) &
                             (board[LINE_TABLE[l][1]] == X) &
                             (board[LINE_TABLE[l][2]] == X));
      o_line_s = o_line_s | ((board[LINE_TABLE[l][0]] == O) &
                             (board[LINE_TABLE[l][1]] == O) &
                             (board[LINE_TABLE[l][2]] == O));
    end
    if (x_line_s) begin
      winner = X;
    end else if (o_line_s) begin
      winner = O;
    end else begin
      winner = EMPTY;
    end
    anyLine = x_line_s | o_line_s;
  end

endmodule

// File: rtl/board_sequencer.sv
// Owns the board RAM: clears it after reset, validates and writes moves,
// then rescans the board into a shadow copy and evaluates the game result.
module board_sequencer #(
  parameter int CELLS = 9,
  parameter int AW    = 4
) (
  input  logic          ph1,
  input  logic          reset,
  input  logic          wrReq,
  input  logic [AW-1:0] wrAddr,
  input  logic [1:0]    wrCell,
  output logic          wrGrant,
  output logic          illegalMove,
  output logic [AW-1:0] memAddr,
  output logic          memWe,
  output logic [1:0]    memWData,
  input  logic [1:0]    memRData,
  output logic          busy,
  output logic          gameIsDone,
  output logic [1:0]    winner,
  output logic          isDraw
);
  import tictactoe_pkg::*;

  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0] SCAN_END  = AW'(CELLS);
  localparam logic [3:0]    FULL      = 4'd9;

  seq_state_t              state_r, state_s;
  logic [AW-1:0]           idx_r, idx_s;
  logic [AW-1:0]           addr_r, addr_s;
  logic [1:0]              cell_r, cell_s;
  logic [3:0]              moves_r, moves_s;
  logic [CELLS-1:0][1:0]   shadow_r, shadow_s;
  logic                    illegal_r, illegal_s;
  logic [1:0]              winner_r, winner_s;
  logic                    draw_r, draw_s;
  logic [1:0]              line_winner_s;
  logic                    any_line_s;

  win_detect u_win_detect (
    .board   (shadow_r),
    .winner  (line_winner_s),
    .anyLine (any_line_s)
  );

  // State register and datapath registers with synchronous reset.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      idx_r     <= {AW{1'b0}};
      addr_r    <= {AW{1'b0}};
      cell_r    <= EMPTY;
      moves_r   <= 4'd0;
      shadow_r  <= {CELLS{EMPTY}};
      illegal_r <= 1'b0;
      winner_r  <= EMPTY;
      draw_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      addr_r    <= addr_s;
      cell_r    <= cell_s;
      moves_r   <= moves_s;
      shadow_r  <= shadow_s;
      illegal_r <= illegal_s;
      winner_r  <= winner_s;
      draw_r    <= draw_s;
    end
  end

  // Next-state and output decode; reset masks every output immediately.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    addr_s      = addr_r;
    cell_s      = cell_r;
    moves_s     = moves_r;
    shadow_s    = shadow_r;
    illegal_s   = 1'b0;
    winner_s    = winner_r;
    draw_s      = draw_r;
    wrGrant     = 1'b0;
    memAddr     = {AW{1'b0}};
    memWe       = 1'b0;
    memWData    = EMPTY;
    illegalMove = illegal_r;
    busy        = !((state_r == ST_IDLE) || (state_r == ST_DONE));
    gameIsDone  = (state_r == ST_DONE);
    winner      = winner_r;
    isDraw      = draw_r;
    if (reset) begin
      illegalMove = 1'b0;
      busy        = 1'b1;
      gameIsDone  = 1'b0;
      winner      = EMPTY;
      isDraw      = 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          memWe   = 1'b1;
          memAddr = idx_r;
          if (idx_r == LAST_CELL) begin
            idx_s   = {AW{1'b0}};
            state_s = ST_IDLE;
          end else begin
            idx_s = idx_r + AW'(1'b1);
          end
        end
        ST_IDLE: begin
          if (wrReq && ((wrAddr > LAST_CELL) || !wrCell[1])) begin
            illegal_s = 1'b1;
          end else if (wrReq) begin
            addr_s  = wrAddr;
            cell_s  = wrCell;
            state_s = ST_RDCHK;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RDCHK: begin
          memAddr = addr_r;
          state_s = ST_VERIFY;
        end
        ST_VERIFY: begin
          // Bit 1 set means X or O; code 01 reads as empty.
          if (memRData[1]) begin
            illegal_s = 1'b1;
            state_s   = ST_IDLE;
          end else begin
            state_s = ST_WRITE;
          end
        end
        ST_WRITE: begin
          memWe    = 1'b1;
          memAddr  = addr_r;
          memWData = cell_r;
          wrGrant  = 1'b1;
          moves_s  = (moves_r == FULL) ? FULL : moves_r + 4'd1;
          idx_s    = {AW{1'b0}};
          state_s  = ST_SCAN;
        end
        ST_SCAN: begin
          memAddr = (idx_r <= LAST_CELL) ? idx_r : {AW{1'b0}};
          if (idx_r != {AW{1'b0}}) begin
            shadow_s[idx_r - AW'(1'b1)] = memRData;
          end else begin
            shadow_s = shadow_r;
          end
          if (idx_r == SCAN_END) begin
            idx_s   = {AW{1'b0}};
            state_s = ST_EVAL;
          end else begin
            idx_s = idx_r + AW'(1'b1);
          end
        end
        ST_EVAL: begin
          if (any_line_s) begin
            winner_s = line_winner_s;
            state_s  = ST_DONE;
          end else if (moves_r == FULL) begin
            draw_s  = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          idx_s   = {AW{1'b0}};
          state_s = ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_sequencer.sv
// Scoreboard bench for board_sequencer: a behavioural RAM, expected pulses
// queued at request time and matched as the sequencer answers.
module tb_board_sequencer;

  typedef struct {
    bit ill;
    int start;
    int lat;
  } exp_t;

  logic       ph1;
  logic       reset;
  logic       wrReq;
  logic [3:0] wrAddr;
  logic [1:0] wrCell;
  logic       wrGrant;
  logic       illegalMove;
  logic [3:0] memAddr;
  logic       memWe;
  logic [1:0] memWData;
  logic [1:0] rdata;
  logic       busy;
  logic       gameIsDone;
  logic [1:0] winner;
  logic       isDraw;

  logic [1:0] ram [0:15];
  int         cyc;
  int         we_cnt;
  int         pulse_cnt;
  int         checks;
  int         errors;
  exp_t       sbq [$];

  board_sequencer #(.CELLS(9), .AW(4)) dut (
    .ph1         (ph1),
    .reset       (reset),
    .wrReq       (wrReq),
    .wrAddr      (wrAddr),
    .wrCell      (wrCell),
    .wrGrant     (wrGrant),
    .illegalMove (illegalMove),
    .memAddr     (memAddr),
    .memWe       (memWe),
    .memWData    (memWData),
    .memRData    (rdata),
    .busy        (busy),
    .gameIsDone  (gameIsDone),
    .winner      (winner),
    .isDraw      (isDraw)
  );

  initial begin
    ph1 = 1'b0;
    forever #5 ph1 = ~ph1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Single-port read-first RAM with one-cycle read latency.
  always @(posedge ph1) begin
    cyc <= cyc + 1;
    if (memWe) begin
      ram[memAddr] <= memWData;
      we_cnt       <= we_cnt + 1;
    end
    rdata <= ram[memAddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Match every pulse against the oldest queued expectation.
  always @(negedge ph1) begin : monitor
    exp_t e;
    if (wrGrant || illegalMove) begin
      pulse_cnt++;
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {30'd0, wrGrant, illegalMove}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", {30'd0, wrGrant, illegalMove}, e.ill ? 32'd1 : 32'd2);
        check("pulse_latency", cyc - e.start, e.lat);
      end
    end
  end

  // Called at a negedge: assert reset, hold two edges, then verify the clear sweep.
  task automatic do_reset();
    reset = 1'b1;
    wrReq = 1'b0;
    #1;
    check("rst_memWe", {31'd0, memWe}, 32'd0);
    check("rst_memAddr", {28'd0, memAddr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_outputs", {27'd0, gameIsDone, winner, isDraw, wrGrant}, 32'd0);
    repeat (2) @(negedge ph1);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #1;
      check("clr_we_addr_data", {25'd0, memWe, memAddr, memWData}, {25'd0, 1'b1, 4'(k), 2'b00});
      check("clr_busy", {31'd0, busy}, 32'd1);
      @(negedge ph1);
    end
    #1;
    check("clr_end_busy_we", {30'd0, busy, memWe}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      check("clr_ram", {30'd0, ram[k]}, 32'd0);
    end
    @(negedge ph1);
  endtask

  // Called at a negedge with the sequencer idle.
  task automatic do_move(input logic [3:0] a, input logic [1:0] c, input bit ill, input int lat,
                         input bit done_e, input logic [1:0] win_e, input bit draw_e);
    exp_t e;
    int   k;
    int   w0;
    w0      = we_cnt;
    e.ill   = ill;
    e.start = cyc;
    e.lat   = lat;
    sbq.push_back(e);
    wrAddr = a;
    wrCell = c;
    wrReq  = 1'b1;
    k = 0;
    do begin
      @(negedge ph1);
      k++;
    end while (!(wrGrant || illegalMove) && k < 20);
    wrReq = 1'b0;
    check("pulse_seen", {31'd0, wrGrant | illegalMove}, 32'd1);
    if (ill) begin
      check("illegal_no_write", we_cnt - w0, 32'd0);
      @(negedge ph1);
    end else begin
      k = 0;
      while (busy && k < 30) begin
        @(negedge ph1);
        k++;
      end
      check("result_latency", cyc - e.start, 32'd15);
      check("ram_written", {30'd0, ram[a]}, {30'd0, c});
      check("done_flag", {31'd0, gameIsDone}, {31'd0, done_e});
      check("winner", {30'd0, winner}, {30'd0, win_e});
      check("draw_flag", {31'd0, isDraw}, {31'd0, draw_e});
    end
  endtask

  initial begin
    int p0;
    int w0;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    we_cnt    = 0;
    pulse_cnt = 0;
    reset     = 1'b1;
    wrReq     = 1'b0;
    wrAddr    = 4'd0;
    wrCell    = 2'b00;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 2'b11;
    end
    @(negedge ph1);
    do_reset();

    do_move(4'd4, 2'b10, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd4, 2'b11, 1'b1, 3, 1'b0, 2'b00, 1'b0);
    check("ram4_kept", {30'd0, ram[4]}, 32'd2);
    do_move(4'd9, 2'b10, 1'b1, 1, 1'b0, 2'b00, 1'b0);
    do_move(4'd0, 2'b01, 1'b1, 1, 1'b0, 2'b00, 1'b0);
    do_move(4'd1, 2'b00, 1'b1, 1, 1'b0, 2'b00, 1'b0);

    // Reset lands mid-SCAN after X@0 was granted.
    begin : scan_reset
      exp_t e;
      int   k;
      e.ill = 1'b0; e.start = cyc; e.lat = 3;
      sbq.push_back(e);
      wrAddr = 4'd0; wrCell = 2'b10; wrReq = 1'b1;
      k = 0;
      do begin
        @(negedge ph1);
        k++;
      end while (!wrGrant && k < 20);
      wrReq = 1'b0;
      check("scan_rst_grant_seen", {31'd0, wrGrant}, 32'd1);
      repeat (3) @(negedge ph1);
      p0 = pulse_cnt;
      do_reset();
      check("scan_rst_no_pulse", pulse_cnt - p0, 32'd0);
    end

    do_move(4'd0, 2'b10, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd3, 2'b11, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd1, 2'b10, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd4, 2'b11, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd2, 2'b10, 1'b0, 3, 1'b1, 2'b10, 1'b0);

    p0 = pulse_cnt;
    w0 = we_cnt;
    wrAddr = 4'd5; wrCell = 2'b11; wrReq = 1'b1;
    repeat (6) @(negedge ph1);
    wrReq = 1'b0;
    check("done_no_pulse", pulse_cnt - p0, 32'd0);
    check("done_no_write", we_cnt - w0, 32'd0);
    check("done_held", {29'd0, gameIsDone, winner}, 32'd6);

    do_reset();
    do_move(4'd0, 2'b10, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd1, 2'b11, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd2, 2'b10, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd3, 2'b10, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd4, 2'b11, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd5, 2'b11, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd6, 2'b11, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd7, 2'b10, 1'b0, 3, 1'b0, 2'b00, 1'b0);
    do_move(4'd8, 2'b10, 1'b0, 3, 1'b1, 2'b00, 1'b1);

    check("sb_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
